// File: rtl/lc3b_types.sv
// Shared types for the alg_unit sequencing logic.
package lc3b_types;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_LOAD,
    ST_HOLD
  } alg_seq_state_t;

  typedef enum logic [1:0] {
    ALG_NONE = 2'b00,
    ALG_MUL  = 2'b01,
    ALG_DIV  = 2'b10,
    ALG_MOD  = 2'b11
  } alg_op_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/alg_seq_ctrl.sv
// Sequences one alg_unit operation per EX instruction and
// stalls the front of the pipe until the result is loaded.
module alg_seq_ctrl
  import lc3b_types::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_alg_op,
  input  logic [1:0]       ex_op_x_bits,
  input  logic             pipe_stall,
  input  logic             pipe_flush,
  input  logic             alg_done,
  output logic             alg_start,
  output logic [1:0]       alg_op,
  output logic             load_alg_reg,
  output logic             ex_stall,
  output logic             res_valid,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WD_W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT - 1);

  alg_seq_state_t state, next;
  alg_op_t        op_q;
  logic [WD_W-1:0] wd_q;
  logic           terr_q;

  logic start_c, load_c, stall_c, hold_c;
  logic set_terr, req;

  assign res_valid = (state == ST_HOLD) & ~rst;
  assign req = ex_valid & ex_alg_op
             & ~pipe_flush & ~res_valid;

  always_comb begin
    next     = state;
    start_c  = 1'b0;
    load_c   = 1'b0;
    stall_c  = 1'b0;
    hold_c   = 1'b0;
    set_terr = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          stall_c = 1'b1;
          next    = ST_START;
        end
      end
      ST_START: begin
        start_c = 1'b1;
        stall_c = 1'b1;
        next = pipe_flush ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        // flush beats done, done beats expiry
        if (pipe_flush)
          next = ST_IDLE;
        else if (alg_done)
          next = ST_LOAD;
        else if (wd_q == WD_LAST) begin
          next     = ST_LOAD;
          set_terr = 1'b1;
        end
      end
      ST_LOAD: begin
        load_c  = 1'b1;
        stall_c = 1'b1;
        next = pipe_flush ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        hold_c = 1'b1;
        if (pipe_flush || !pipe_stall)
          next = ST_IDLE;
      end
      default: next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      wd_q   <= '0;
      op_q   <= ALG_NONE;
      terr_q <= 1'b0;
    end else begin
      state <= next;
      if (state == ST_WAIT && next == ST_WAIT)
        wd_q <= wd_q + 1'b1;
      else
        wd_q <= '0;
      if (state == ST_IDLE && next == ST_START)
        op_q <= alg_op_t'(ex_op_x_bits);
      if (set_terr)
        terr_q <= 1'b1;
    end
  end

  assign alg_start    = start_c & ~rst;
  assign load_alg_reg = load_c & ~rst;
  assign ex_stall     = stall_c & ~rst;
  assign alg_op       = op_q;
  assign timeout_err  = terr_q;

  logic unused_hold;
  assign unused_hold = hold_c;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ex_stall),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_alg_seq_ctrl.sv
// Bench for alg_seq_ctrl: vector table, corner sequences, random run.
module tb_alg_seq_ctrl;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst, ex_valid, ex_alg_op;
  logic [1:0] ex_op_x_bits;
  logic pipe_stall, pipe_flush, alg_done;

  logic        alg_start, load_alg_reg, ex_stall;
  logic        res_valid, timeout_err;
  logic [1:0]  alg_op;
  logic [15:0] stall_cycles;

  logic        s_start, s_load, s_stall, s_rv, s_terr;
  logic [1:0]  s_op;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  alg_seq_ctrl #(.TIMEOUT(TO), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alg_op(ex_alg_op),
    .ex_op_x_bits(ex_op_x_bits),
    .pipe_stall(pipe_stall), .pipe_flush(pipe_flush),
    .alg_done(alg_done),
    .alg_start(alg_start), .alg_op(alg_op),
    .load_alg_reg(load_alg_reg), .ex_stall(ex_stall),
    .res_valid(res_valid), .timeout_err(timeout_err),
    .stall_cycles(stall_cycles)
  );

  alg_seq_ctrl #(.TIMEOUT(TO), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alg_op(ex_alg_op),
    .ex_op_x_bits(ex_op_x_bits),
    .pipe_stall(pipe_stall), .pipe_flush(pipe_flush),
    .alg_done(alg_done),
    .alg_start(s_start), .alg_op(s_op),
    .load_alg_reg(s_load), .ex_stall(s_stall),
    .res_valid(s_rv), .timeout_err(s_terr),
    .stall_cycles(s_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // reference: an op is tracked by its age in cycles since the
  // request cycle; m_load_age is the age at which it loads
  bit         m_act;
  int         m_age, m_load_age;
  logic [1:0] m_op;
  bit         m_terr;
  int         m_cnt16, m_cnt4;
  bit         e_start, e_load, e_stall, e_rv;

  task automatic model_expect();
    bit req;
    req = ex_valid & ex_alg_op & !pipe_flush;
    e_start = 0; e_load = 0; e_stall = 0; e_rv = 0;
    if (!m_act) e_stall = req;
    else if (m_age == 1) begin
      e_start = 1; e_stall = 1;
    end else if (m_load_age < 0) e_stall = 1;
    else if (m_age == m_load_age) begin
      e_load = 1; e_stall = 1;
    end else e_rv = 1;
    if (rst) begin
      e_start = 0; e_load = 0; e_stall = 0; e_rv = 0;
    end
  endtask

  task automatic check_model();
    model_expect();
    chk("alg_start", alg_start, e_start);
    chk("load_alg_reg", load_alg_reg, e_load);
    chk("ex_stall", ex_stall, e_stall);
    chk("res_valid", res_valid, e_rv);
    chk("alg_op", alg_op, m_op);
    chk("timeout_err", timeout_err, m_terr);
    chk("stall_cycles", stall_cycles, m_cnt16);
    chk("stall_cycles_w4", s_cnt, m_cnt4);
  endtask

  task automatic model_adv();
    if (rst) begin
      m_act = 0; m_op = 0; m_terr = 0;
      m_cnt16 = 0; m_cnt4 = 0;
      return;
    end
    if (e_stall) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (!m_act) begin
      if (ex_valid && ex_alg_op && !pipe_flush) begin
        m_act = 1; m_age = 1; m_load_age = -1;
        m_op = ex_op_x_bits;
      end
    end else if (m_age == 1) begin
      if (pipe_flush) m_act = 0;
      else m_age++;
    end else if (m_load_age < 0) begin
      if (pipe_flush) m_act = 0;
      else begin
        if (alg_done) m_load_age = m_age + 1;
        else if (m_age - 2 == TO - 1) begin
          m_terr = 1; m_load_age = m_age + 1;
        end
        m_age++;
      end
    end else if (m_age == m_load_age) begin
      if (pipe_flush) m_act = 0;
      else m_age++;
    end else begin
      if (pipe_flush || !pipe_stall) m_act = 0;
      else m_age++;
    end
  endtask

  task automatic drive(input bit r, v, a,
                       input logic [1:0] b,
                       input bit s, f, d);
    @(negedge clk);
    rst = r; ex_valid = v; ex_alg_op = a;
    ex_op_x_bits = b; pipe_stall = s;
    pipe_flush = f; alg_done = d;
    #1;
  endtask

  task automatic cyc(input bit r, v, a,
                     input logic [1:0] b,
                     input bit s, f, d);
    drive(r, v, a, b, s, f, d);
    check_model();
    model_adv();
  endtask

  typedef struct {
    bit r, v, a;
    logic [1:0] b;
    bit s, f, d;
    bit x_start, x_load, x_stall, x_rv;
    logic [1:0] x_op;
    int x_cnt;
  } vec_t;

  function automatic vec_t mk(
    bit v, bit d, bit s,
    bit xs, bit xl, bit xst, bit xrv,
    logic [1:0] xop, int xc);
    vec_t t;
    t.r = 0; t.v = v; t.a = v; t.b = 2'b01;
    t.s = s; t.f = 0; t.d = d;
    t.x_start = xs; t.x_load = xl;
    t.x_stall = xst; t.x_rv = xrv;
    t.x_op = xop; t.x_cnt = xc;
    return t;
  endfunction

  vec_t tbl[8];

  initial begin
    int n;
    int n2;
    rst = 1; ex_valid = 0; ex_alg_op = 0;
    ex_op_x_bits = 0; pipe_stall = 0;
    pipe_flush = 0; alg_done = 0;
    m_act = 0; m_op = 0; m_terr = 0;
    m_cnt16 = 0; m_cnt4 = 0;
    m_age = 0; m_load_age = -1;

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 2'b01, 0, 0, 0);

    // mul, done on third WAIT cycle
    tbl[0] = mk(1, 0, 1, 0, 0, 1, 0, 2'b00, 0);
    tbl[1] = mk(1, 0, 1, 1, 0, 1, 0, 2'b01, 1);
    tbl[2] = mk(1, 0, 1, 0, 0, 1, 0, 2'b01, 2);
    tbl[3] = mk(1, 0, 1, 0, 0, 1, 0, 2'b01, 3);
    tbl[4] = mk(1, 1, 1, 0, 0, 1, 0, 2'b01, 4);
    tbl[5] = mk(1, 0, 1, 0, 1, 1, 0, 2'b01, 5);
    tbl[6] = mk(1, 0, 0, 0, 0, 0, 1, 2'b01, 6);
    tbl[7] = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 6);
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].b,
            tbl[i].s, tbl[i].f, tbl[i].d);
      check_model();
      chk($sformatf("tbl%0d_start", i),
          alg_start, tbl[i].x_start);
      chk($sformatf("tbl%0d_load", i),
          load_alg_reg, tbl[i].x_load);
      chk($sformatf("tbl%0d_stall", i),
          ex_stall, tbl[i].x_stall);
      chk($sformatf("tbl%0d_rv", i),
          res_valid, tbl[i].x_rv);
      chk($sformatf("tbl%0d_op", i),
          alg_op, tbl[i].x_op);
      chk($sformatf("tbl%0d_cnt", i),
          stall_cycles, tbl[i].x_cnt);
      model_adv();
    end

    // watchdog expiry: 8 WAIT cycles, one load, then advance
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 1, 2'b10, 0, 0, 0);
      n += int'(load_alg_reg);
    end
    chk("to_load_count", n, 1);
    chk("to_err", timeout_err, 1);
    chk("to_stall_drop", ex_stall, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // flush on WAIT cycle 2, late done ignored
    cyc(0, 1, 1, 2'b11, 0, 0, 0);
    cyc(0, 1, 1, 2'b11, 0, 0, 0);
    cyc(0, 1, 1, 2'b11, 0, 0, 0);
    cyc(0, 1, 1, 2'b11, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("fl_stall", ex_stall, 0);
    n = 0; n2 = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      n += int'(load_alg_reg);
      n2 += int'(res_valid);
    end
    chk("fl_no_load", n, 0);
    chk("fl_no_rv", n2, 0);

    // HOLD under pipe_stall for 4 cycles
    cyc(0, 1, 1, 2'b10, 0, 0, 0);
    cyc(0, 1, 1, 2'b10, 0, 0, 0);
    cyc(0, 1, 1, 2'b10, 0, 0, 1);
    cyc(0, 1, 1, 2'b10, 0, 0, 0);
    n = 0; n2 = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 2'b10, 1, 0, 0);
      n += int'(res_valid);
      n2 += int'(alg_start) + int'(ex_stall);
    end
    chk("hold_rv_cycles", n, 4);
    chk("hold_no_restart", n2, 0);
    cyc(0, 1, 1, 2'b10, 0, 0, 0);
    chk("hold_exit_rv", res_valid, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("hold_after_rv", res_valid, 0);

    // reset while in WAIT
    cyc(0, 1, 1, 2'b01, 0, 0, 0);
    cyc(0, 1, 1, 2'b01, 0, 0, 0);
    cyc(0, 1, 1, 2'b01, 0, 0, 0);
    cyc(1, 1, 1, 2'b01, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_start", alg_start, 0);
    chk("rst_load", load_alg_reg, 0);
    chk("rst_stall", ex_stall, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_op", alg_op, 0);
    chk("rst_cnt", stall_cycles, 0);

    // repeated ops saturate the narrow counter
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 1, 2'b01, 0, 0, 0);
      cyc(0, 1, 1, 2'b01, 0, 0, 0);
      cyc(0, 1, 1, 2'b01, 0, 0, 1);
      cyc(0, 1, 1, 2'b01, 0, 0, 0);
      cyc(0, 1, 1, 2'b01, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
    end
    chk("sat_w4", s_cnt, 15);
    chk("sat_w16", stall_cycles, 20);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) != 0),
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
